// File: rtl/mailbox_fifo_pkg.sv
// Shared types and helpers for the producer/consumer mailbox.
// The wrapping increment avoids power-of-two masking so any DEPTH >= 2 works.
package mailbox_pkg;

  typedef enum logic {FILL, DRAIN} mbx_state_e;

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mailbox_fifo_if.sv
// Valid/ready word stream; the mailbox is the slave on the producer side
// and the master on the consumer side.
interface mailbox_fifo_if #(
  parameter int DATA_W = 4
);

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/mailbox_fifo_ram.sv
// Mailbox storage: one synchronous write port and one asynchronous read port.
// The contents are deliberately not reset.
module mailbox_ram #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 10,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk1,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk1) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mailbox_fifo.sv
// Parametrised mailbox between a producer and a consumer on one clock, with an
// optional batch-release FSM, sticky overflow, flush and fill level.
module mailbox_fifo
  import mailbox_pkg::*;
#(
  parameter  int DATA_W      = 4,
  parameter  int DEPTH       = 10,
  parameter  int BATCH_MODE  = 1,
  parameter  int BATCH_LEVEL = 10,
  localparam int LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             flush,
  mailbox_fifo_if.slave    prod,
  mailbox_fifo_if.master   cons,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic             batch_done
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  mbx_state_e       state;
  mbx_state_e       state_nxt;
  logic             batch_done_nxt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             clear;

  // Readiness depends on the registered level only, so a pop never frees room same-cycle.
  assign full       = (level == LVL_W'(DEPTH));
  assign empty      = (level == '0);
  assign clear      = !rst_n || flush;
  assign prod.ready = !full;
  assign cons.valid = (BATCH_MODE == 0) ? !empty : ((state == DRAIN) && !empty);
  assign push       = prod.valid && prod.ready;
  assign pop        = cons.valid && cons.ready;

  mailbox_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk1  (clk1),
    .we    (push && !clear),
    .waddr (wr_ptr),
    .wdata (prod.data),
    .raddr (rd_ptr),
    .rdata (cons.data)
  );

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop && !push) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  always_comb begin
    state_nxt      = state;
    batch_done_nxt = 1'b0;
    if (BATCH_MODE == 0) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL: begin
          if (level_nxt >= LVL_W'(BATCH_LEVEL)) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (level_nxt == '0) begin
            state_nxt      = FILL;
            batch_done_nxt = 1'b1;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  // Reset takes priority over flush, and both discard any same-cycle push or pop.
  always_ff @(posedge clk1) begin
    if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      state      <= FILL;
      batch_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
      end
      if (pop) begin
        rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
      end
      if (prod.valid && !prod.ready) begin
        overflow <= 1'b1;
      end
      level      <= level_nxt;
      state      <= state_nxt;
      batch_done <= batch_done_nxt;
    end
  end

endmodule
